dispensador_ctrl: RTL

Order scheduler for the RGB dosing motors. Queues up to DEPTH colour orders (R, G, B amounts), then runs them one at a time, switching on each motor in turn (R, then G, then B) for amount × UNIT_TICKS clock cycles. Sits between the user-entry logic, which produces the amounts and the enter strobe, and the motor drivers. It replaces single-shot timing with buffered, back-to-back sequencing.

---
 rtl/dispensador_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/dispensador_ctrl.sv
// -----------------------------------------------------------------------------
// dispensador_ctrl
//
// Order scheduler for the RGB dosing motors. Colour orders (R, G, B amounts)
// are buffered in a small FIFO and executed one at a time. Each colour's motor
// runs for amount x UNIT_TICKS clock cycles, in the order R, then G, then B.
//
// Parameters
//   W           width of each colour amount
//   DEPTH       order FIFO entries (power of two, >= 2)
//   UNIT_TICKS  clk cycles per amount unit (>= 1)
//
// Ports
//   clk                        system clock, all logic on posedge
//   rst                        synchronous active-high reset
//   pause                      freeze execution (only with DISP_PAUSE_EN)
//   order_valid                an order is offered this cycle
//   order_R/order_G/order_B    amounts, taken when order_valid && order_ready
//   order_ready                FIFO has room (low whenever full)
//   motor_R/motor_G/motor_B    motor enables, at most one high at a time
//   busy                       an order is executing (high through DONE)
//   done                       one-cycle pulse when an order finishes
//   pending                    orders queued, excluding the executing one
//
// Configuration
//   DISP_PAUSE_EN  when defined, adds the pause input. While pause is high the
//                  RUN states hold their counters with all motors off, and no
//                  new order is popped from IDLE. The FIFO still accepts.
// -----------------------------------------------------------------------------
module dispensador_ctrl #(
  parameter int W          = 5,
  parameter int DEPTH      = 4,
  parameter int UNIT_TICKS = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef DISP_PAUSE_EN
  input  logic                     pause,
`endif
  input  logic                     order_valid,
  input  logic [W-1:0]             order_R,
  input  logic [W-1:0]             order_G,
  input  logic [W-1:0]             order_B,
  output logic                     order_ready,
  output logic                     motor_R,
  output logic                     motor_G,
  output logic                     motor_B,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(UNIT_TICKS - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_R,
    S_RUN_G,
    S_RUN_B,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] g;
    logic [W-1:0] b;
  } order_t;

  // ---------------------------------------------------------------------------
  // Freeze control
  // ---------------------------------------------------------------------------
  logic hold;
`ifdef DISP_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Order FIFO
  // ---------------------------------------------------------------------------
  order_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  order_t        head;

  assign full        = (count == COUNT_FULL);
  assign empty       = (count == '0);
  // Readiness depends only on the registered count; a pop in the same cycle
  // does not open a slot early.
  assign order_ready = !full;
  assign push        = order_valid && !full;
  assign head        = mem[rd_ptr];
  assign pending     = count;

  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the values present before the clock edge.
  // NOTE: the storage array is deliberately not reset; count and pointers
  // define which entries are live, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{r: order_R, g: order_G, b: order_B};
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Execution FSM
  // ---------------------------------------------------------------------------
  state_t        state,      state_next;
  logic [W-1:0]  units_left, units_next;
  logic [TW-1:0] tick_cnt,   tick_next;
  logic [W-1:0]  act_g,      act_g_next;
  logic [W-1:0]  act_b,      act_b_next;
  logic          running;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      units_left <= '0;
      tick_cnt   <= '0;
      act_g      <= '0;
      act_b      <= '0;
    end else begin
      state      <= state_next;
      units_left <= units_next;
      tick_cnt   <= tick_next;
      act_g      <= act_g_next;
      act_b      <= act_b_next;
    end
  end

  // The motor of the current RUN state is on while units remain; the cycle
  // in which units_left reads zero has the motor off and advances the state.
  assign running = (units_left != '0) && !hold;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_next = state;
    units_next = units_left;
    tick_next  = tick_cnt;
    act_g_next = act_g;
    act_b_next = act_b;
    pop        = 1'b0;
    done       = 1'b0;
    motor_R    = 1'b0;
    motor_G    = 1'b0;
    motor_B    = 1'b0;

    case (state)
      S_IDLE: begin
        if (!empty && !hold) begin
          pop        = 1'b1;
          act_g_next = head.g;
          act_b_next = head.b;
          units_next = head.r;
          tick_next  = '0;
          state_next = S_RUN_R;
        end
      end

      S_RUN_R, S_RUN_G, S_RUN_B: begin
        motor_R = running && (state == S_RUN_R);
        motor_G = running && (state == S_RUN_G);
        motor_B = running && (state == S_RUN_B);
        if (!hold) begin
          if (units_left != '0) begin
            // Count units rather than total cycles so no amount x UNIT_TICKS
            // product is ever needed.
            if (tick_cnt == TICK_LAST) begin
              tick_next  = '0;
              units_next = units_left - W'(1);
            end else begin
              tick_next  = tick_cnt + TW'(1);
            end
          end else begin
            case (state)
              S_RUN_R: begin
                state_next = S_RUN_G;
                units_next = act_g;
              end
              S_RUN_G: begin
                state_next = S_RUN_B;
                units_next = act_b;
              end
              default: begin
                state_next = S_DONE;
                units_next = '0;
              end
            endcase
          end
        end
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule
